// File: rtl/vga_scanout_if.sv
// Screen-side frame-buffer read port plus VGA pixel/sync outputs of vga_scanout.
// master = scanout engine, slave = memory/display side.
interface vga_scanout_if;
    logic [14:0] rd_addr;
    logic [11:0] rd_data;
    logic [11:0] rgb;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;

    modport master (
        output rd_addr, rgb, hsync, vsync, de, frame_start,
        input  rd_data
    );

    modport slave (
        input  rd_addr, rgb, hsync, vsync, de, frame_start,
        output rd_data
    );
endinterface

// File: rtl/vga_scanout.sv
// 800x600@72 VGA scanout reading a x4-upscaled 200x150 RGB444 frame buffer (1-clk read latency).
// Optional white one-pixel frame border: define VGA_BORDER_EN.
module vga_scanout #(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned H_FP        = 56,
    parameter int unsigned H_SYNC      = 120,
    parameter int unsigned H_BP        = 64,
    parameter int unsigned V_ACTIVE    = 600,
    parameter int unsigned V_FP        = 37,
    parameter int unsigned V_SYNC      = 6,
    parameter int unsigned V_BP        = 23,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned FB_W        = H_ACTIVE >> SCALE_SHIFT
) (
    input  logic          clk,
    input  logic          rstn,
    vga_scanout_if.master bus
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_ON      = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_OFF     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_ON      = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_OFF     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [14:0]   ROW_STEP   = 15'(FB_W);

    logic [HW-1:0]          h_cnt;
    logic [VW-1:0]          v_cnt;
    logic                   active, hs, vs, fs, line_end, frame_end;
    logic [SCALE_SHIFT-1:0] x_sub, y_sub;
    logic [14:0]            x_img, row_base;
    logic [2:0]             act_d, hs_d, vs_d, fs_d;
    logic [11:0]            pix;

    always_comb begin
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs        = (h_cnt >= HS_ON) && (h_cnt < HS_OFF);
        vs        = (v_cnt >= VS_ON) && (v_cnt < VS_OFF);
        fs        = (h_cnt == '0) && (v_cnt == '0);
        line_end  = (h_cnt == H_LAST);
        frame_end = line_end && (v_cnt == V_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (line_end) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Incremental address: x_img = h>>SCALE_SHIFT, row_base = (v>>SCALE_SHIFT)*FB_W.
    // row_base overshoots after the last visible line but is cleared at frame wrap before any use.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_sub       <= '0;
            x_img       <= '0;
            y_sub       <= '0;
            row_base    <= '0;
            bus.rd_addr <= '0;
        end else begin
            if (active) begin
                bus.rd_addr <= row_base + x_img;
                if (h_cnt == H_ACT_LAST) begin
                    x_sub <= '0;
                    x_img <= '0;
                    y_sub <= y_sub + 1'b1;
                    if (&y_sub)
                        row_base <= row_base + ROW_STEP;
                end else begin
                    x_sub <= x_sub + 1'b1;
                    if (&x_sub)
                        x_img <= x_img + 1'b1;
                end
            end
            if (frame_end) begin
                y_sub    <= '0;
                row_base <= '0;
            end
        end
    end

`ifdef VGA_BORDER_EN
    localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
    logic       edge_px;
    logic [1:0] edge_d;

    always_comb begin
        edge_px = active && ((h_cnt == '0) || (h_cnt == H_ACT_LAST) ||
                             (v_cnt == '0) || (v_cnt == V_ACT_LAST));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            edge_d <= '0;
        else
            edge_d <= {edge_d[0], edge_px};
    end

    always_comb pix = edge_d[1] ? 12'hFFF : bus.rd_data;
`else
    always_comb pix = bus.rd_data;
`endif

    // rgb is registered from stage 1 so it lines up with stage 2 of the flag pipeline.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_d   <= '0;
            hs_d    <= '0;
            vs_d    <= '0;
            fs_d    <= '0;
            bus.rgb <= '0;
        end else begin
            act_d   <= {act_d[1:0], active};
            hs_d    <= {hs_d[1:0], hs};
            vs_d    <= {vs_d[1:0], vs};
            fs_d    <= {fs_d[1:0], fs};
            bus.rgb <= act_d[1] ? pix : 12'h000;
        end
    end

    assign bus.de          = act_d[2];
    assign bus.hsync       = hs_d[2];
    assign bus.vsync       = vs_d[2];
    assign bus.frame_start = fs_d[2];
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: full-size instance for line/row timing, reduced instance for whole frames.
// Honours VGA_BORDER_EN (memory then returns 12'h123 everywhere).
module tb_vga_scanout;
    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
    } pix_t;

    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    vga_scanout_if big_if ();
    vga_scanout_if small_if ();

    vga_scanout u_big (
        .clk  (clk),
        .rstn (rstn),
        .bus  (big_if.master)
    );

    vga_scanout #(
        .H_ACTIVE    (16),
        .H_FP        (2),
        .H_SYNC      (3),
        .H_BP        (2),
        .V_ACTIVE    (12),
        .V_FP        (2),
        .V_SYNC      (2),
        .V_BP        (2),
        .SCALE_SHIFT (1),
        .FB_W        (8)
    ) u_small (
        .clk  (clk),
        .rstn (rstn),
        .bus  (small_if.master)
    );

    // Timing of instance 0 (full size) and 1 (reduced); small frame = 23 x 18 = 414 clk.
    int unsigned HA  [2] = '{800, 16};
    int unsigned HFP [2] = '{56, 2};
    int unsigned HSY [2] = '{120, 3};
    int unsigned HBP [2] = '{64, 2};
    int unsigned VA  [2] = '{600, 12};
    int unsigned VFP [2] = '{37, 2};
    int unsigned VSY [2] = '{6, 2};
    int unsigned VBP [2] = '{23, 2};
    int unsigned SS  [2] = '{2, 1};
    int unsigned FBW [2] = '{200, 8};

    function automatic logic [11:0] mem_word(input logic [14:0] a);
`ifdef VGA_BORDER_EN
        return (a == 15'h7fff) ? 12'h000 : 12'h123;
`else
        return a[11:0];
`endif
    endfunction

    always @(posedge clk) begin
        big_if.rd_data   <= mem_word(big_if.rd_addr);
        small_if.rd_data <= mem_word(small_if.rd_addr);
    end

    int unsigned         mh [2];
    int unsigned         mv [2];
    logic [14:0]         mlast [2];
    pix_t [1:0]          pq [$];
    logic [1:0][14:0]    aq [$];

    int   cyc, first_fs, de_rise, de_width, hs_rise, hs_width, sfs_last, sfs_period;
    logic prev_de, prev_hs;

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[inst%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
        end
    endtask

    task automatic reset_model();
        pix_t [1:0] zp;
        logic [1:0][14:0] za;
        zp = '0;
        za = '0;
        for (int i = 0; i < 2; i++) begin
            mh[i]    = 0;
            mv[i]    = 0;
            mlast[i] = '0;
        end
        pq.delete();
        aq.delete();
        repeat (3) pq.push_back(zp);
        aq.push_back(za);
        cyc = 0; first_fs = -1; de_rise = -1; de_width = -1;
        hs_rise = -1; hs_width = -1; sfs_last = -1; sfs_period = -1;
        prev_de = 1'b0; prev_hs = 1'b0;
    endtask

    task automatic sample_cycle();
        pix_t [1:0]       obs, exp;
        logic [1:0][14:0] obs_a, exp_a;
        logic             act;
`ifdef VGA_BORDER_EN
        logic             bord;
`endif
        obs[0]   = {big_if.rgb, big_if.hsync, big_if.vsync, big_if.de, big_if.frame_start};
        obs[1]   = {small_if.rgb, small_if.hsync, small_if.vsync, small_if.de, small_if.frame_start};
        obs_a[0] = big_if.rd_addr;
        obs_a[1] = small_if.rd_addr;

        if (pq.size() == 3) begin
            exp = pq.pop_front();
            for (int i = 0; i < 2; i++) begin
                check("rgb", i, 32'(obs[i].rgb), 32'(exp[i].rgb));
                check("hsync", i, 32'(obs[i].hs), 32'(exp[i].hs));
                check("vsync", i, 32'(obs[i].vs), 32'(exp[i].vs));
                check("de", i, 32'(obs[i].de), 32'(exp[i].de));
                check("frame_start", i, 32'(obs[i].fs), 32'(exp[i].fs));
            end
        end
        if (aq.size() == 1) begin
            exp_a = aq.pop_front();
            for (int i = 0; i < 2; i++)
                check("rd_addr", i, 32'(obs_a[i]), 32'(exp_a[i]));
        end

        if (obs[0].de && !prev_de && de_rise < 0) de_rise = cyc;
        if (!obs[0].de && prev_de && de_width < 0 && de_rise >= 0) de_width = cyc - de_rise;
        if (obs[0].hs && !prev_hs && hs_rise < 0 && de_rise >= 0) hs_rise = cyc;
        if (!obs[0].hs && prev_hs && hs_width < 0 && hs_rise >= 0) hs_width = cyc - hs_rise;
        if (obs[0].fs && first_fs < 0) first_fs = cyc;
        if (obs[1].fs) begin
            if (sfs_last >= 0 && sfs_period < 0) sfs_period = cyc - sfs_last;
            sfs_last = cyc;
        end
        prev_de = obs[0].de;
        prev_hs = obs[0].hs;

        for (int i = 0; i < 2; i++) begin
            act = (mh[i] < HA[i]) && (mv[i] < VA[i]);
            if (act)
                mlast[i] = 15'((mv[i] >> SS[i]) * FBW[i] + (mh[i] >> SS[i]));
            exp[i].hs  = (mh[i] >= HA[i] + HFP[i]) && (mh[i] < HA[i] + HFP[i] + HSY[i]);
            exp[i].vs  = (mv[i] >= VA[i] + VFP[i]) && (mv[i] < VA[i] + VFP[i] + VSY[i]);
            exp[i].de  = act;
            exp[i].fs  = (mh[i] == 0) && (mv[i] == 0);
            exp[i].rgb = act ? mem_word(mlast[i]) : 12'h000;
`ifdef VGA_BORDER_EN
            bord = act && (mh[i] == 0 || mh[i] == HA[i] - 1 || mv[i] == 0 || mv[i] == VA[i] - 1);
            if (bord) exp[i].rgb = 12'hFFF;
`endif
            exp_a[i] = mlast[i];
            mh[i]++;
            if (mh[i] == HA[i] + HFP[i] + HSY[i] + HBP[i]) begin
                mh[i] = 0;
                mv[i]++;
                if (mv[i] == VA[i] + VFP[i] + VSY[i] + VBP[i]) mv[i] = 0;
            end
        end
        pq.push_back(exp);
        aq.push_back(exp_a);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            sample_cycle();
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rgb"}, 0, 32'(big_if.rgb), 32'h0);
        check({tag, "_sync"}, 0, 32'({big_if.hsync, big_if.vsync}), 32'h0);
        check({tag, "_de_fs"}, 0, 32'({big_if.de, big_if.frame_start}), 32'h0);
        check({tag, "_rd_addr"}, 0, 32'(big_if.rd_addr), 32'h0);
        check({tag, "_rgb"}, 1, 32'(small_if.rgb), 32'h0);
        check({tag, "_sync"}, 1, 32'({small_if.hsync, small_if.vsync}), 32'h0);
        check({tag, "_de_fs"}, 1, 32'({small_if.de, small_if.frame_start}), 32'h0);
        check({tag, "_rd_addr"}, 1, 32'(small_if.rd_addr), 32'h0);
    endtask

    task automatic check_timing(input string tag);
        check({tag, "_first_frame_start"}, 0, first_fs, 3);
        check({tag, "_de_width"}, 0, de_width, 800);
        check({tag, "_de_to_hsync"}, 0, hs_rise - de_rise, 856);
        check({tag, "_hsync_width"}, 0, hs_width, 120);
        check({tag, "_frame_period"}, 1, sfs_period, 414);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");

        // Nine full-size lines: covers row steps at lines 4 and 8 plus ~24 small frames.
        rstn = 1'b1;
        reset_model();
        run(9 * 1040 + 500);
        check_timing("run1");

        // Asynchronous reset in mid-frame, held 5 clk.
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        repeat (5) @(negedge clk);
        check_reset_outputs("rst_hold");

        rstn = 1'b1;
        reset_model();
        run(2000);
        check_timing("run2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
